// File: rtl/vctr_pkg.sv
// Shared types, width helpers and default parameters for the vector-rate output blocks.
package vctr_pkg;

    typedef enum logic [0:0] {
        VCTR_IDLE,
        VCTR_ACTIVE
    } vctr_state_e;

    localparam int unsigned VCTR_DATA_W        = 8;
    localparam int unsigned VCTR_NUM_CH        = 3;
    localparam int unsigned VCTR_SLOT_LEN      = 20;
    localparam int unsigned VCTR_CLK_DIV       = 625;
    localparam int unsigned VCTR_TIMEOUT_TICKS = 4096;

    function automatic int unsigned vctr_cnt_w(input int unsigned slot_len);
        return $clog2(slot_len + 1);
    endfunction

    function automatic int unsigned vctr_ch_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/vctr_tick_gen.sv
// Free-running divider producing a one-cycle enable every CLK_DIV clocks.
module vctr_tick_gen
    import vctr_pkg::*;
#(
    parameter int unsigned CLK_DIV = VCTR_CLK_DIV
) (
    input  logic clock,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/vctr_demux.sv
// Marker-steered demultiplexer from the vector sample stream into NUM_CH channel registers.
// Optional loss-of-marker timeout is enabled with `define VCTR_DEMUX_TIMEOUT_EN.
module vctr_demux
    import vctr_pkg::*;
#(
    parameter int unsigned DATA_W        = VCTR_DATA_W,
    parameter int unsigned NUM_CH        = VCTR_NUM_CH,
    parameter int unsigned SLOT_LEN      = VCTR_SLOT_LEN,
    parameter int unsigned CLK_DIV       = VCTR_CLK_DIV,
    parameter int unsigned TIMEOUT_TICKS = VCTR_TIMEOUT_TICKS
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        vctr_data_out,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_active,
    output logic                     sample_tick,
    output logic                     slot_done,
    output logic                     timeout
);

    localparam int unsigned CNT_W = vctr_cnt_w(SLOT_LEN);
    localparam int unsigned CH_W  = vctr_ch_w(NUM_CH);

    vctr_state_e              state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_CH*DATA_W-1:0] data_q, data_d;
    logic [NUM_CH-1:0]        valid_q, valid_d;
    logic                     done_q, done_d;
    logic                     to_q, to_d;
    logic                     is_marker;
    logic                     write_en;

`ifdef VCTR_DEMUX_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`else
    logic [31:0] unused_timeout_ticks;
    assign unused_timeout_ticks = TIMEOUT_TICKS;
`endif

    vctr_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clock (clock),
        .rst   (rst),
        .tick  (sample_tick)
    );

    assign is_marker = (vctr_data_out < DATA_W'(NUM_CH));

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = '0;
        done_d   = 1'b0;
        to_d     = 1'b0;
        write_en = 1'b0;
`ifdef VCTR_DEMUX_TIMEOUT_EN
        tcnt_d   = tcnt_q;
`endif
        if (sample_tick) begin
            if (is_marker) begin
                state_d = VCTR_ACTIVE;
                ch_d    = CH_W'(vctr_data_out);
                cnt_d   = '0;
`ifdef VCTR_DEMUX_TIMEOUT_EN
                tcnt_d  = '0;
`endif
            end else begin
`ifdef VCTR_DEMUX_TIMEOUT_EN
                // Timeout pre-empts the write that would otherwise land on this tick.
                if (tcnt_q == TCNT_W'(TIMEOUT_TICKS - 1)) begin
                    data_d  = '0;
                    state_d = VCTR_IDLE;
                    to_d    = 1'b1;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d   = tcnt_q + 1'b1;
                    write_en = (state_q == VCTR_ACTIVE);
                end
`else
                write_en = (state_q == VCTR_ACTIVE);
`endif
            end
        end

        if (write_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_q == CH_W'(k)) begin
                    data_d[k*DATA_W +: DATA_W] = vctr_data_out;
                    valid_d[k]                 = 1'b1;
                end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(SLOT_LEN - 1)) begin
                done_d  = 1'b1;
                state_d = VCTR_IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= VCTR_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
`ifdef VCTR_DEMUX_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            to_q    <= to_d;
`ifdef VCTR_DEMUX_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
`endif
        end
    end

    always_comb begin
        ch_active = '0;
        if (state_q == VCTR_ACTIVE) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_q == CH_W'(k)) begin
                    ch_active[k] = 1'b1;
                end
            end
        end
    end

    assign ch_data   = data_q;
    assign ch_valid  = valid_q;
    assign slot_done = done_q;
    assign timeout   = to_q;

endmodule
